// File: rtl/viterbi_tx_rx_2b5.sv
// viterbi_tx_rx_2b5: rate-1/2 K=3 (7,5) convolutional encoder, a channel that
// flips one code bit every ERR_PERIOD symbols, and a hard-decision
// register-exchange Viterbi decoder. The decoded stream is delayed so that the
// overall latency from encoder_i to decoder_o is exactly TOTAL_LAT clocks.
module viterbi_tx_rx_2b5 #(
    parameter int TOTAL_LAT  = 4104,
    parameter int TB_DEPTH   = 64,
    parameter int ERR_PERIOD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic encoder_i,
    input  logic enable_encoder_i,
    output logic decoder_o
);

    // The survivor window and the decision register consume TB_DEPTH+1 clocks
    // of the budget; the circular buffer absorbs the rest.
    localparam int DLY = TOTAL_LAT - TB_DEPTH - 1;
    localparam int PW  = (DLY > 1) ? $clog2(DLY) : 1;

    // Hamming weight of a 2-bit difference.
    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

    // Code symbol {c0,c1} leaving state p = {b[n-1], b[n-2]} on input bit b.
    function automatic logic [1:0] branch_out(input logic [1:0] p, input logic b);
        return {b ^ p[1] ^ p[0], b ^ p[0]};
    endfunction

    // ---------------- encoder and channel ----------------
    logic [1:0]  enc_state_q;
    logic [1:0]  sym_q;
    logic [31:0] word_ct;
    logic [1:0]  err_inj;
    logic [31:0] error_counter;
    logic        bit_in;
    logic        err_hit;
    logic [32:0] err_sum;
    logic [1:0]  rx;

    assign bit_in  = enable_encoder_i & encoder_i;
    assign err_hit = enable_encoder_i &&
                     ((word_ct % 32'(ERR_PERIOD)) == 32'(ERR_PERIOD - 1));
    assign err_sum = {1'b0, error_counter} + {32'd0, err_inj[1]} + {32'd0, err_inj[0]};
    assign rx      = sym_q ^ err_inj;

    // Encoder shift register, symbol register, error mask and error statistics.
    always_ff @(posedge clk) begin
        if (!rst) begin
            enc_state_q   <= 2'b00;
            sym_q         <= 2'b00;
            word_ct       <= 32'd0;
            err_inj       <= 2'b00;
            error_counter <= 32'd0;
        end else begin
            enc_state_q <= {bit_in, enc_state_q[1]};
            sym_q       <= {bit_in ^ enc_state_q[1] ^ enc_state_q[0], bit_in ^ enc_state_q[0]};
            if (enable_encoder_i) begin
                word_ct <= word_ct + 32'd1;
            end
            err_inj       <= err_hit ? 2'b01 : 2'b00;
            error_counter <= err_sum[32] ? '1 : err_sum[31:0];
        end
    end

    // ---------------- add-compare-select ----------------
    logic [7:0]          pm_q   [4];
    logic [7:0]          pm_d   [4];
    logic [TB_DEPTH-1:0] surv_q [4];
    logic [TB_DEPTH-1:0] surv_d [4];
    logic [8:0]          m0     [4];
    logic [8:0]          m1     [4];
    logic [8:0]          cand   [4];
    logic                all_big;

    // State s = {b[n], b[n-1]} is reached from {s[0],0} and {s[0],1} on input s[1];
    // ties keep the lower-numbered predecessor.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            m0[s] = {1'b0, pm_q[(s % 2) * 2]} +
                    {7'd0, hamming(rx, branch_out(2'((s % 2) * 2), s >= 2))};
            m1[s] = {1'b0, pm_q[(s % 2) * 2 + 1]} +
                    {7'd0, hamming(rx, branch_out(2'((s % 2) * 2 + 1), s >= 2))};
            cand[s]   = m0[s];
            surv_d[s] = {surv_q[(s % 2) * 2][TB_DEPTH-2:0], s >= 2};
            if (m1[s] < m0[s]) begin
                cand[s]   = m1[s];
                surv_d[s] = {surv_q[(s % 2) * 2 + 1][TB_DEPTH-2:0], s >= 2};
            end
        end
        all_big = (cand[0] > 9'd127) && (cand[1] > 9'd127) &&
                  (cand[2] > 9'd127) && (cand[3] > 9'd127);
        for (int s = 0; s < 4; s++) begin
            pm_d[s] = all_big ? 8'(cand[s] - 9'd128) : cand[s][7:0];
        end
    end

    // Path metric and survivor registers; state 0 starts favoured.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < 4; s++) begin
                pm_q[s]   <= (s == 0) ? 8'd0 : 8'd64;
                surv_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 4; s++) begin
                pm_q[s]   <= pm_d[s];
                surv_q[s] <= surv_d[s];
            end
        end
    end

    // ---------------- decision and delay line ----------------
    logic [1:0] best_s;
    logic       oldest;

    // Minimum-metric state, lowest index on ties; its oldest survivor bit is the decision.
    always_comb begin
        best_s = 2'd0;
        for (int s = 1; s < 4; s++) begin
            if (pm_q[s] < pm_q[best_s]) begin
                best_s = 2'(s);
            end
        end
        oldest = surv_q[best_s][TB_DEPTH-1];
    end

    logic          dly_mem_q [DLY];
    logic [PW-1:0] ptr_q;
    logic          dec_q;

    // Circular buffer: read the entry written DLY clocks ago, then overwrite it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DLY; i++) begin
                dly_mem_q[i] <= 1'b0;
            end
            ptr_q <= '0;
            dec_q <= 1'b0;
        end else begin
            dec_q            <= dly_mem_q[ptr_q];
            dly_mem_q[ptr_q] <= oldest;
            ptr_q            <= (ptr_q == PW'(DLY - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    assign decoder_o = dec_q;

endmodule

// File: tb/tb_viterbi_tx_rx_2b5.sv
// Bench for viterbi_tx_rx_2b5: every clock the applied bit is queued, and the
// entry queued TOTAL_LAT clocks earlier is checked against decoder_o.
module tb_viterbi_tx_rx_2b5;

    localparam int TOTAL_LAT = 4104;

    logic clk;
    logic rst;
    logic encoder_i;
    logic enable_encoder_i;
    logic decoder_o;

    int   total;
    int   bad;
    logic exp_cur;
    logic q[$];

    viterbi_tx_rx_2b5 #(
        .TOTAL_LAT (TOTAL_LAT),
        .TB_DEPTH  (64),
        .ERR_PERIOD(16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .encoder_i       (encoder_i),
        .enable_encoder_i(enable_encoder_i),
        .decoder_o       (decoder_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
        end
    endtask

    // One clock: update the scoreboard from the inputs sampled at this edge,
    // check decoder_o shortly after the edge, then drive the next inputs.
    task automatic step(input logic b, input logic en, input logic r);
        @(posedge clk);
        if (!rst) begin
            q.delete();
            repeat (TOTAL_LAT + 1) q.push_back(1'b0);
        end else begin
            q.push_back(encoder_i & enable_encoder_i);
        end
        exp_cur = q.pop_front();
        #2;
        chk("decoder_o", {31'd0, decoder_o}, {31'd0, exp_cur});
        encoder_i        = b;
        enable_encoder_i = en;
        rst              = r;
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst              = 1'b0;
        encoder_i        = 1'b0;
        enable_encoder_i = 1'b0;

        // Ten reset clocks, with a stray 1 offered that must be ignored.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("rst_word_ct", dut.word_ct, 32'd0);
            chk("rst_err_cnt", dut.error_counter, 32'd0);
            if (i == 9) begin
                chk("rst_pm0", {24'd0, dut.pm_q[0]}, 32'd0);
                chk("rst_pm3", {24'd0, dut.pm_q[3]}, 32'd64);
            end
        end

        // Runs of 1s and 0s of length 1..5, twice, then an alternating tail.
        for (int rep = 0; rep < 2; rep++) begin
            for (int len = 1; len <= 5; len++) begin
                repeat (len) step(1'b1, 1'b1, 1'b1);
                repeat (len) step(1'b0, 1'b1, 1'b1);
            end
        end
        for (int i = 0; i < 8; i++) step(1'(i % 2 == 0), 1'b1, 1'b1);

        // Random bits, then runs of 10 and 100 ones.
        repeat (20) step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (100) step(1'b1, 1'b1, 1'b1);

        // Drain everything through the decoder.
        repeat (TOTAL_LAT + 5) step(1'b0, 1'b1, 1'b1);

        // Random data in flight, then a one-clock reset mid-stream.
        repeat (200) step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("mid_pm0", {24'd0, dut.pm_q[0]}, 32'd0);
        chk("mid_pm1", {24'd0, dut.pm_q[1]}, 32'd64);
        chk("mid_word_ct", dut.word_ct, 32'd0);
        repeat (TOTAL_LAT + 3) step(1'b0, 1'b1, 1'b1);

        // Fresh reset, then exactly 1000 enabled random bits.
        step(1'b0, 1'b0, 1'b0);
        step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        chk("run_err_cnt0", dut.error_counter, 32'd0);
        repeat (999) step(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("run_word_ct", dut.word_ct, 32'd1000);
        chk("run_err_cnt", dut.error_counter, 32'd62);

        // Disabled encoder with encoder_i=1: counter holds, output drains to 0.
        repeat (TOTAL_LAT + 10) step(1'b1, 1'b0, 1'b1);
        chk("hold_word_ct", dut.word_ct, 32'd1000);
        chk("hold_err_cnt", dut.error_counter, 32'd62);
        chk("hold_dec", {31'd0, decoder_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
